// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings, ALU operation and core state types.
// Imported by the multicycle core and its ALU.
package riscv_pkg;

    // Instruction fields
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;

    localparam logic [6:0] CLASS_LOAD   = 7'b0000011;
    localparam logic [6:0] CLASS_OP_IMM = 7'b0010011;
    localparam logic [6:0] CLASS_AUIPC  = 7'b0010111;
    localparam logic [6:0] CLASS_STORE  = 7'b0100011;
    localparam logic [6:0] CLASS_OP     = 7'b0110011;
    localparam logic [6:0] CLASS_LUI    = 7'b0110111;
    localparam logic [6:0] CLASS_BRANCH = 7'b1100011;
    localparam logic [6:0] CLASS_JALR   = 7'b1100111;
    localparam logic [6:0] CLASS_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MEM_W = 3'b010;
    localparam logic [2:0] F3_MEM_D = 3'b011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {FETCH, EXECUTE, MEMORY, HALT} core_state_t;

    // alt selects SUB/SRA (instr[30])
    function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational XLEN-wide integer ALU; also provides the branch compares.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;

    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV64I integer core: FETCH -> EXECUTE [-> MEMORY] -> FETCH,
// halting on any illegal or misaligned operation until reset.
module multicycle_core
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            n_rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted
);

    localparam int unsigned ALN    = $clog2(XLEN / 8);
    localparam logic [2:0]  F3_MEM = (XLEN == 64) ? F3_MEM_D : F3_MEM_W;

    core_state_t     r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_regs [32];
    logic            r_imem_req, r_dmem_req, r_dmem_we, r_retire, r_halted;
    logic [XLEN-1:0] r_dmem_addr, r_dmem_wdata;

    logic [6:0]      w_opcode, w_funct7;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_pc_plus4;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_alu_b, w_alu_res, w_target, w_wb_data, w_next_pc;
    alu_op_t         w_alu_op;
    logic            w_illegal, w_wb_en, w_is_mem, w_is_store, w_taken, w_sh_bad;

    assign w_opcode = r_instr[OPC_LSB +: 7];
    assign w_rd     = r_instr[RD_LSB +: 5];
    assign w_funct3 = r_instr[F3_LSB +: 3];
    assign w_rs1    = r_instr[RS1_LSB +: 5];
    assign w_rs2    = r_instr[RS2_LSB +: 5];
    assign w_funct7 = r_instr[F7_LSB +: 7];

    // x0 is never written, so it reads back as zero
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + XLEN'(4);

    assign w_imm_i = XLEN'($signed(r_instr[31:20]));
    assign w_imm_s = XLEN'($signed({r_instr[31:25], r_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0}));

    assign w_sh_bad = (XLEN == 32) && r_instr[25];

    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_b  = w_rs2_val;
        case (w_opcode)
            CLASS_OP_IMM: begin
                w_alu_op = alu_op_decode(w_funct3, (w_funct3 == F3_SRL) && r_instr[30]);
                w_alu_b  = w_imm_i;
            end
            CLASS_OP:                w_alu_op = alu_op_decode(w_funct3, r_instr[30]);
            CLASS_JALR, CLASS_LOAD:  w_alu_b = w_imm_i;
            CLASS_STORE:             w_alu_b = w_imm_s;
            CLASS_BRANCH: w_alu_op = w_funct3[2] ? (w_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_XOR;
            default: ;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_rs1_val),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res)
    );

    // funct3[0] inverts the base compare: BNE/BGE/BGEU
    assign w_taken = (w_funct3[2] ? w_alu_res[0] : (w_alu_res == '0)) ^ w_funct3[0];

    always_comb begin
        w_illegal  = 1'b0;
        w_wb_en    = 1'b0;
        w_wb_data  = w_alu_res;
        w_next_pc  = w_pc_plus4;
        w_target   = w_pc_plus4;
        w_is_mem   = 1'b0;
        w_is_store = 1'b0;
        case (w_opcode)
            CLASS_OP_IMM: begin
                w_wb_en = 1'b1;
                if (w_funct3 == F3_SLL)
                    w_illegal = (r_instr[31:26] != 6'b0) || w_sh_bad;
                else if (w_funct3 == F3_SRL)
                    w_illegal = ({r_instr[31], r_instr[29:26]} != 5'b0) || w_sh_bad;
            end
            CLASS_OP: begin
                w_wb_en   = 1'b1;
                w_illegal = !((w_funct7 == 7'b0) || ((w_funct7 == 7'b0100000) &&
                              ((w_funct3 == F3_ADD) || (w_funct3 == F3_SRL))));
            end
            CLASS_LUI: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_imm_u;
            end
            CLASS_AUIPC: begin
                w_wb_en   = 1'b1;
                w_wb_data = r_pc + w_imm_u;
            end
            CLASS_JAL: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_target  = r_pc + w_imm_j;
                w_next_pc = w_target;
                w_illegal = (w_target[1:0] != 2'b0);
            end
            CLASS_JALR: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_target  = {w_alu_res[XLEN-1:1], 1'b0};
                w_next_pc = w_target;
                w_illegal = (w_funct3 != 3'b0) || (w_target[1:0] != 2'b0);
            end
            CLASS_BRANCH: begin
                w_target = r_pc + w_imm_b;
                if ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)) begin
                    w_illegal = 1'b1;
                end else if (w_taken) begin
                    w_next_pc = w_target;
                    w_illegal = (w_target[1:0] != 2'b0);
                end
            end
            CLASS_LOAD, CLASS_STORE: begin
                w_is_mem   = 1'b1;
                w_is_store = (w_opcode == CLASS_STORE);
                w_illegal  = (w_funct3 != F3_MEM) || (w_alu_res[ALN-1:0] != '0);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_VECTOR;
            r_instr      <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (r_imem_req && imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= EXECUTE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                EXECUTE: begin
                    if (w_illegal) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_is_mem) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_store;
                        r_dmem_addr  <= w_alu_res;
                        r_dmem_wdata <= w_rs2_val;
                        r_state      <= MEMORY;
                    end else begin
                        if (w_wb_en && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb_data;
                        r_pc       <= w_next_pc;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                MEMORY: begin
                    if (r_dmem_req && dmem_ready) begin
                        if (!r_dmem_we && (w_rd != 5'd0)) r_regs[w_rd] <= dmem_rdata;
                        r_pc       <= w_pc_plus4;
                        r_retire   <= 1'b1;
                        r_dmem_req <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign retire     = r_retire;
    assign halted     = r_halted;

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle RISC-V integer core, successor to the single-cycle core.
- Fetches over a valid/ready instruction port and executes the full RV32I/RV64I base ALU, branch, jump, LUI/AUIPC and XLEN-wide load/store set.
- Uses a separate valid/ready data port that can stall for any number of cycles.
- Halts on an illegal or misaligned operation. Sits between the instruction/data memory models and the top-level SoC.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64.
- RESET_VECTOR, 0, value loaded into PC on reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, synchronous, active-low
- imem_req  output  1  instruction fetch request valid
- imem_addr  output  XLEN  fetch address (= PC)
- imem_ready  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- dmem_req  output  1  data access request valid
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  XLEN  data byte address
- dmem_wdata  output  XLEN  store data
- dmem_ready  input  1  access complete; dmem_rdata valid on loads
- dmem_rdata  input  XLEN  load data
- retire  output  1  one-cycle pulse per committed instruction
- halted  output  1  core in HALT state

Behaviour:
- Reset (n_rst low at posedge):
  - PC = RESET_VECTOR, x1..x31 = 0, state = FETCH.
  - imem_req = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, retire = 0, halted = 0 (all registered).
  - Reset mid-transaction abandons the request. Memories must tolerate a request dropped without ready.
- FETCH:
  - imem_req = 1 and imem_addr = PC, held stable until imem_ready.
  - On imem_ready, latch imem_rdata into the instruction register; next state is EXECUTE.
- EXECUTE (exactly 1 cycle):
  - Decode the instruction; the ALU evaluates combinationally.
  - OP_IMM/OP ops: ADD/SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SUB and SRA are selected by instr[30]. Immediate shifts use instr[25:20] when XLEN=64, otherwise instr[24:20]; instr[25]=1 is illegal when XLEN=32.
  - Register shift amount = rs2[$clog2(XLEN)-1:0]. Arithmetic wraps mod 2^XLEN. Immediates are sign-extended to XLEN.
  - LUI: rd = sext(imm_u). AUIPC: rd = PC + sext(imm_u).
  - JAL: rd = PC+4, PC = PC + imm_j.
  - JALR: rd = PC+4, PC = (rs1 + imm_i) & ~1. Compute the target from the old rs1 when rd == rs1.
  - BRANCH: BEQ/BNE/BLT/BGE/BLTU/BGEU. Taken sets PC = PC + imm_b, otherwise PC+4.
  - Non-memory instructions commit at the end of EXECUTE: retire = 1 next cycle; next state FETCH.
  - LOAD/STORE: compute the address rs1 + imm, latch addr/wdata/we; next state MEMORY.
  - Writes to x0 are discarded; x0 always reads 0.
- MEMORY:
  - dmem_req = 1 with addr/we/wdata held stable until dmem_ready.
  - On dmem_ready, a load writes dmem_rdata to rd and a store writes nothing. PC += 4, retire pulses, next state FETCH.
- Legal load/store: funct3 == 3'b010 when XLEN=32, 3'b011 when XLEN=64. Any other width is illegal.
- HALT conditions, checked in EXECUTE with no commit and no retire:
  - Unsupported opcode or funct3/funct7.
  - Taken jump/branch target with bits[1:0] != 0.
  - Load/store address not aligned to XLEN/8.
- HALT state:
  - PC frozen at the faulting instruction; no requests; halted = 1.
  - Only reset exits HALT.
- Minimum latency: 2 cycles per ALU/branch instruction with zero-wait memories; 3 cycles per load/store.
- Requests are never withdrawn before ready. Ready arriving while req = 0 is ignored.

Decomposition:
- Additions to riscv_pkg:
  - Class constants CLASS_OP, CLASS_LUI, CLASS_AUIPC, CLASS_JALR, CLASS_BRANCH, CLASS_LOAD.
  - funct3 constants for ALU, branch and memory-width encodings.
  - alu_op_t enum.
  - core_state_t enum {FETCH, EXECUTE, MEMORY, HALT}.
  - Immediate-format field positions.
- One sub-module: alu (XLEN-parametrised, combinational; inputs a, b, alu_op_t; output result). Branch comparison reuses the SLT/SLTU paths.

Test Plan:
- Zero-wait memories, program `addi x1,x0,5; addi x2,x1,-7; sub x3,x1,x2` → x1=5, x2=0xFFFFFFFE, x3=7; retire pulses every 2nd cycle.
- `sw x3,8(x0)` with dmem_ready delayed 3 cycles → dmem_req high with addr=8, wdata=7, we=1 stable for 4 cycles; PC advances only after ready.
- `lw x4,8(x0)` with dmem_rdata=0xDEADBEEF → x4=0xDEADBEEF; `lw x0,...` leaves x0=0.
- Branches: `blt x2,x1,+8` with x2=-2, x1=5 → taken (PC+8); `bltu` with the same operands → not taken (PC+4). `jalr x1,x1,3` with x1=0x100 → PC=0x102, then halted=1 with PC held at 0x102 is NOT reached; instead the halt fires at EXECUTE because the target is misaligned, PC stays at the jalr address and x1 is unchanged.
- Illegal opcode 0x0000007F → halted=1 one cycle after EXECUTE, no retire, no further imem_req. Assert n_rst → PC=RESET_VECTOR, halted=0.
- XLEN=64: `slli x5,x5,40` with x5=1 → x5=0x0000010000000000; `ld` with address 0x1004 → halt (misaligned). Reset asserted during an imem stall → imem_req=0 next cycle, PC=RESET_VECTOR.
